// File: rtl/sync_stream_fifo_pkg.sv
// Shared constants and helpers for the sync_stream_fifo block.
package sync_stream_fifo_pkg;

  localparam int MODE_BACKPRESSURE = 0;
  localparam int MODE_OVERWRITE    = 1;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit over the address width.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_stream_fifo_ram.sv
// Simple dual-port RAM for sync_stream_fifo: one write port and one registered read port.
// Read data is held between read enables, so it also serves as the FIFO output data register.
module sync_stream_fifo_ram
  import sync_stream_fifo_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int WIDTH  = 512,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: storage and read register carry no reset so this maps onto block RAM;
  // the controller never reads an address in the same cycle it writes it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sync_stream_fifo.sv
// Single-clock FWFT stream FIFO with valid/ready on both sides, flush and occupancy status.
// Define SYNC_STREAM_FIFO_DROP_CNT_EN to implement the saturating overwrite drop counter.
module sync_stream_fifo
  import sync_stream_fifo_pkg::*;
#(
  parameter int DEPTH     = 64,
  parameter int WIDTH     = 512,
  parameter int MODE      = MODE_BACKPRESSURE,
  parameter int AF_THRESH = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [WIDTH-1:0]        m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [cnt_w(DEPTH)-1:0] count,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic [31:0]             drop_cnt
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = cnt_w(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              out_valid, s_ready;
  logic              wr, pop, drop, load;
  logic [CW-1:0]     ram_cnt, count_next;

  // A push offered during flush completes the handshake but is discarded.
  assign wr      = s_axis_tvalid && s_ready && !flush;
  assign pop     = out_valid && m_axis_tready;
  assign ram_cnt = count - CW'(out_valid);
  // Overwrite at full discards the RAM head, leaving the presented beat untouched.
  assign drop    = (MODE == MODE_OVERWRITE) && wr && full && !pop;
  assign load    = (ram_cnt != '0) && (!out_valid || pop) && !flush;

  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    count_next = count;
    if (wr && !drop) count_next = count_next + CW'(1);
    if (pop)         count_next = count_next - CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only; rst is tested first so it beats flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      out_valid   <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      s_ready     <= 1'b0;
    end else if (flush) begin
      rd_ptr      <= wr_ptr;
      out_valid   <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      s_ready     <= 1'b1;
    end else begin
      if (wr)           wr_ptr <= wr_ptr + ADDR_W'(1);
      if (load || drop) rd_ptr <= rd_ptr + ADDR_W'(1);
      if (load)         out_valid <= 1'b1;
      else if (pop)     out_valid <= 1'b0;
      count       <= count_next;
      full        <= (count_next == CW'(DEPTH));
      empty       <= (count_next == '0);
      almost_full <= (count_next >= CW'(AF_THRESH));
      // Registered from next occupancy: a pop at full cannot admit a push in the same cycle.
      s_ready     <= (MODE == MODE_OVERWRITE) || (count_next != CW'(DEPTH));
    end
  end

`ifdef SYNC_STREAM_FIFO_DROP_CNT_EN
  logic [31:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst)                        drop_q <= '0;
    else if (drop && drop_q != '1)  drop_q <= drop_q + 32'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

  sync_stream_fifo_ram #(
    .DEPTH  (DEPTH),
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr),
    .wr_addr (wr_ptr),
    .wr_data (s_axis_tdata),
    .rd_en   (load),
    .rd_addr (rd_ptr),
    .rd_data (m_axis_tdata)
  );

  assign s_axis_tready = s_ready;
  assign m_axis_tvalid = out_valid;

endmodule

// File: tb/tb_sync_stream_fifo.sv
// Directed bench for sync_stream_fifo: u_bp is DEPTH=8 backpressure, u_ow is DEPTH=8 overwrite.
module tb_sync_stream_fifo;
  import sync_stream_fifo_pkg::*;

  localparam int DEPTH = 8;
  localparam int WIDTH = 16;
  localparam int AF    = 6;
  localparam int CW    = cnt_w(DEPTH);
`ifdef SYNC_STREAM_FIFO_DROP_CNT_EN
  localparam logic [31:0] DROPS_EXP = 32'd2;
`else
  localparam logic [31:0] DROPS_EXP = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic             a_flush = 1'b0, a_s_valid = 1'b0, a_m_ready = 1'b0;
  logic [WIDTH-1:0] a_s_data = '0, a_m_data;
  logic             a_s_ready, a_m_valid, a_full, a_empty, a_af;
  logic [CW-1:0]    a_count;
  logic [31:0]      a_drop;

  logic             b_flush = 1'b0, b_s_valid = 1'b0, b_m_ready = 1'b0;
  logic [WIDTH-1:0] b_s_data = '0, b_m_data;
  logic             b_s_ready, b_m_valid, b_full, b_empty, b_af;
  logic [CW-1:0]    b_count;
  logic [31:0]      b_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_stream_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MODE(MODE_BACKPRESSURE), .AF_THRESH(AF)) u_bp (
    .clk(clk), .rst(rst), .flush(a_flush),
    .s_axis_tdata(a_s_data), .s_axis_tvalid(a_s_valid), .s_axis_tready(a_s_ready),
    .m_axis_tdata(a_m_data), .m_axis_tvalid(a_m_valid), .m_axis_tready(a_m_ready),
    .count(a_count), .full(a_full), .empty(a_empty), .almost_full(a_af), .drop_cnt(a_drop)
  );

  sync_stream_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MODE(MODE_OVERWRITE), .AF_THRESH(AF)) u_ow (
    .clk(clk), .rst(rst), .flush(b_flush),
    .s_axis_tdata(b_s_data), .s_axis_tvalid(b_s_valid), .s_axis_tready(b_s_ready),
    .m_axis_tdata(b_m_data), .m_axis_tvalid(b_m_valid), .m_axis_tready(b_m_ready),
    .count(b_count), .full(b_full), .empty(b_empty), .almost_full(b_af), .drop_cnt(b_drop)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [40:0] got, exp;
    rst = 1'b1;
    step();
    exp = {1'b0, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    got = {a_m_valid, a_count, a_empty, a_full, a_af, a_s_ready, a_drop};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_bp got %h exp %h", got, exp); end
    got = {b_m_valid, b_count, b_empty, b_full, b_af, b_s_ready, b_drop};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL reset_ow got %h exp %h", got, exp); end
    rst = 1'b0;
    step();
    checks++;
    if ({a_s_ready, b_s_ready} !== 2'b11) begin
      errors++; $display("FAIL ready_after_reset got %b exp 11", {a_s_ready, b_s_ready});
    end
  endtask

  task automatic test_backpressure();
    logic [CW+2:0] got, exp;
    a_m_ready = 1'b0;
    for (int i = 1; i <= DEPTH; i++) begin
      a_s_valid = 1'b1;
      a_s_data  = WIDTH'(i);
      step();
      exp = {CW'(i), i >= AF, i == DEPTH, i != DEPTH};
      got = {a_count, a_af, a_full, a_s_ready};
      checks++;
      if (got !== exp) begin errors++; $display("FAIL fill_%0d got %b exp %b", i, got, exp); end
    end
    checks++;
    if ({a_m_valid, a_m_data} !== {1'b1, 16'h0001}) begin
      errors++; $display("FAIL full_head got %b/%h exp 1/0001", a_m_valid, a_m_data);
    end
    // Pop at full while offering a new beat: the beat must not be taken this cycle.
    a_s_data  = 16'h0099;
    a_m_ready = 1'b1;
    step();
    a_s_valid = 1'b0;
    exp = {CW'(7), 1'b1, 1'b0, 1'b1};
    got = {a_count, a_af, a_full, a_s_ready};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL pop_at_full got %b exp %b", got, exp); end
    for (int j = 2; j <= DEPTH; j++) begin
      checks++;
      if ({a_m_valid, a_m_data} !== {1'b1, WIDTH'(j)}) begin
        errors++; $display("FAIL drain_%0d got %b/%h exp 1/%h", j, a_m_valid, a_m_data, j);
      end
      step();
    end
    a_m_ready = 1'b0;
    checks++;
    if ({a_m_valid, a_empty, a_count} !== {1'b0, 1'b1, CW'(0)}) begin
      errors++; $display("FAIL drained got %b/%b/%0d exp 0/1/0", a_m_valid, a_empty, a_count);
    end
  endtask

  task automatic test_latency();
    a_s_valid = 1'b1;
    a_s_data  = 16'h00AA;
    step();
    a_s_valid = 1'b0;
    checks++;
    if ({a_m_valid, a_empty, a_count} !== {1'b0, 1'b0, CW'(1)}) begin
      errors++; $display("FAIL latency_k got %b/%b/%0d exp 0/0/1", a_m_valid, a_empty, a_count);
    end
    step();
    checks++;
    if ({a_m_valid, a_m_data} !== {1'b1, 16'h00AA}) begin
      errors++; $display("FAIL latency_k1 got %b/%h exp 1/00aa", a_m_valid, a_m_data);
    end
    a_m_ready = 1'b1;
    step();
    a_m_ready = 1'b0;
    checks++;
    if (a_empty !== 1'b1) begin errors++; $display("FAIL latency_pop got %b exp 1", a_empty); end
  endtask

  task automatic test_back_to_back();
    logic exp_v;
    a_m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      a_s_valid = (c < 4);
      a_s_data  = WIDTH'(16'h0010 + c);
      step();
      exp_v = (c >= 1) && (c <= 4);
      checks++;
      if (a_m_valid !== exp_v || (exp_v && a_m_data !== WIDTH'(16'h0010 + c - 1))) begin
        errors++;
        $display("FAIL b2b_%0d got %b/%h exp %b/%h", c, a_m_valid, a_m_data, exp_v, 16'h0010 + c - 1);
      end
    end
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
  endtask

  task automatic test_overwrite();
    b_m_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      b_s_valid = 1'b1;
      b_s_data  = WIDTH'(i);
      step();
    end
    checks++;
    if ({b_count, b_full, b_s_ready, b_drop} !== {CW'(8), 1'b1, 1'b1, DROPS_EXP}) begin
      errors++;
      $display("FAIL ow_full got %0d/%b/%b/%0d exp 8/1/1/%0d", b_count, b_full, b_s_ready, b_drop, DROPS_EXP);
    end
    // Push together with pop at full: no drop, occupancy unchanged.
    b_s_data  = 16'd11;
    b_m_ready = 1'b1;
    step();
    b_s_valid = 1'b0;
    checks++;
    if ({b_count, b_drop, b_m_data} !== {CW'(8), DROPS_EXP, 16'd4}) begin
      errors++; $display("FAIL ow_pushpop got %0d/%0d/%h exp 8/%0d/0004", b_count, b_drop, b_m_data, DROPS_EXP);
    end
    for (int j = 4; j <= 11; j++) begin
      checks++;
      if ({b_m_valid, b_m_data} !== {1'b1, WIDTH'(j)}) begin
        errors++; $display("FAIL ow_drain_%0d got %b/%h exp 1/%h", j, b_m_valid, b_m_data, j);
      end
      step();
    end
    b_m_ready = 1'b0;
    checks++;
    if (b_empty !== 1'b1) begin errors++; $display("FAIL ow_empty got %b exp 1", b_empty); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      b_s_valid = 1'b1;
      b_s_data  = WIDTH'(16'h0020 + i);
      step();
    end
    checks++;
    if (b_count !== CW'(5)) begin errors++; $display("FAIL flush_pre got %0d exp 5", b_count); end
    b_flush  = 1'b1;
    b_s_data = 16'h0077;
    step();
    b_flush   = 1'b0;
    b_s_valid = 1'b0;
    checks++;
    if ({b_count, b_m_valid, b_empty, b_full, b_drop} !== {CW'(0), 1'b0, 1'b1, 1'b0, DROPS_EXP}) begin
      errors++;
      $display("FAIL flush got %0d/%b/%b/%b/%0d exp 0/0/1/0/%0d", b_count, b_m_valid, b_empty, b_full, b_drop, DROPS_EXP);
    end
    b_s_valid = 1'b1;
    b_s_data  = 16'h0033;
    step();
    b_s_valid = 1'b0;
    step();
    checks++;
    if ({b_m_valid, b_m_data, b_count} !== {1'b1, 16'h0033, CW'(1)}) begin
      errors++; $display("FAIL flush_after got %b/%h/%0d exp 1/0033/1", b_m_valid, b_m_data, b_count);
    end
    b_m_ready = 1'b1;
    step();
    b_m_ready = 1'b0;
  endtask

  task automatic test_stream();
    int sent = 0;
    int rcvd = 0;
    int cyc  = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      a_s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      a_s_data  = WIDTH'(sent + 1);
      a_m_ready = ($urandom_range(0, 1) == 1);
      if (a_m_valid && a_m_ready) begin
        checks++;
        if (a_m_data !== WIDTH'(rcvd + 1)) begin
          errors++; $display("FAIL stream_data got %h exp %h", a_m_data, rcvd + 1);
        end
        rcvd++;
      end
      if (a_s_valid && a_s_ready) sent++;
      step();
      cyc++;
      checks++;
      if (a_count !== CW'(sent - rcvd) || a_count > CW'(DEPTH)) begin
        errors++; $display("FAIL stream_count got %0d exp %0d", a_count, sent - rcvd);
      end
    end
    a_s_valid = 1'b0;
    a_m_ready = 1'b0;
    checks++;
    if (rcvd != 1000) begin errors++; $display("FAIL stream_total got %0d exp 1000", rcvd); end
  endtask

  task automatic test_reset_mid();
    logic [40:0] got, exp;
    a_m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_s_valid = 1'b1;
      a_s_data  = WIDTH'(16'h0040 + i);
      step();
    end
    a_s_valid = 1'b0;
    checks++;
    if (a_count !== CW'(6)) begin errors++; $display("FAIL mid_pre got %0d exp 6", a_count); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp = {1'b0, CW'(0), 1'b1, 1'b0, 1'b0, 1'b0, 32'd0};
    got = {a_m_valid, a_count, a_empty, a_full, a_af, a_s_ready, a_drop};
    checks++;
    if (got !== exp) begin errors++; $display("FAIL mid_reset got %h exp %h", got, exp); end
    step();
    a_s_valid = 1'b1;
    a_s_data  = 16'h0055;
    step();
    a_s_valid = 1'b0;
    step();
    checks++;
    if ({a_m_valid, a_m_data, a_count} !== {1'b1, 16'h0055, CW'(1)}) begin
      errors++; $display("FAIL mid_after got %b/%h/%0d exp 1/0055/1", a_m_valid, a_m_data, a_count);
    end
  endtask

  initial begin
    test_reset();
    test_backpressure();
    test_latency();
    test_back_to_back();
    test_overwrite();
    test_flush();
    test_stream();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
